vc_sync_fifo: RTL and testbench

//  Single-clock multi-virtual-channel FIFO for router input ports; successor to the dual-clock FIFO.
//  NVC independent queues share one RAM; one write and one read per cycle, each to any VC.
//  Per-VC full/almost-full/empty/count feed VC allocation and credit return; sticky

---
 rtl/noc_fifo_pkg.sv | 22 ++
 rtl/sdpram.sv | 53 +++++
 rtl/vc_sync_fifo.sv | 132 +++++++++++++
 tb/tb_vc_sync_fifo.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/noc_fifo_pkg.sv
// ---------------------------------------------------------------------------
// noc_fifo_pkg
// Shared constants and types for the multi-virtual-channel router input FIFO.
// The FIFO_* values are the default geometry used by vc_sync_fifo. DEPTH and
// VW are derived from those defaults. ptr_t and flit_t are the matching
// pointer and flit types for that default geometry.
// ---------------------------------------------------------------------------
package noc_fifo_pkg;

    localparam int FIFO_AW    = 4;
    localparam int FIFO_DW    = 16;
    localparam int FIFO_NVC   = 4;
    localparam int FIFO_AFULL = 12;

    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int VW    = (FIFO_NVC > 1) ? $clog2(FIFO_NVC) : 1;

    // Pointers carry one extra wrap bit so that full and empty can be told apart.
    typedef logic [FIFO_AW:0]   ptr_t;
    typedef logic [FIFO_DW-1:0] flit_t;

endpackage

// File: rtl/sdpram.sv
// ---------------------------------------------------------------------------
// sdpram
// Simple dual-port RAM with one write port and one registered read port.
// The read register only loads when re_i is high, so rdata_o holds its last
// value between reads. The read register clears on the read-side reset. The
// storage array itself has no reset.
// Ports:
//   wclk_i            write clock
//   we_i              write enable
//   waddr_i / wdata_i write address / data
//   rclk_i            read clock
//   rrst_ni           async active-low reset of the read register
//   re_i              read enable
//   raddr_i           read address
//   rdata_o           registered read data
// ---------------------------------------------------------------------------
module sdpram #(
    parameter int AW = 6,
    parameter int DW = 16
) (
    input  logic          wclk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          rclk_i,
    input  logic          rrst_ni,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] rdata_q;

    // Write port: plain synchronous write with no reset, so it can map onto block RAM.
    always_ff @(posedge wclk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    // Read port: the output register loads only on a read and otherwise holds its value.
    always_ff @(posedge rclk_i or negedge rrst_ni) begin
        if (!rrst_ni) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/vc_sync_fifo.sv
// ---------------------------------------------------------------------------
// vc_sync_fifo
// Single-clock FIFO with several virtual channels (VCs) for a router input
// port. NVC independent queues share one RAM. Each cycle the FIFO accepts one
// write and one read, and each can target any VC.
// Ports:
//   clk, rstn          clock, async active-low reset
//   write, wvc, din    write request, target VC, flit
//   read, rvc          read request, source VC
//   dout, dout_vld     read data, valid one cycle after an accepted read
//   full, afull, empty per-VC status flags
//   count              per-VC occupancy; VC v is at [v*(AW+1) +: AW+1]
//   ovf_err, udf_err   sticky flags for a write to a full VC / a read from an empty VC
// ---------------------------------------------------------------------------
module vc_sync_fifo
    import noc_fifo_pkg::*;
#(
    parameter  int AW    = FIFO_AW,
    parameter  int DW    = FIFO_DW,
    parameter  int NVC   = FIFO_NVC,
    parameter  int AFULL = FIFO_AFULL,
    localparam int VcW   = (NVC > 1) ? $clog2(NVC) : 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  write,
    input  logic [VcW-1:0]        wvc,
    input  logic [DW-1:0]         din,
    input  logic                  read,
    input  logic [VcW-1:0]        rvc,
    output logic [DW-1:0]         dout,
    output logic                  dout_vld,
    output logic [NVC-1:0]        full,
    output logic [NVC-1:0]        afull,
    output logic [NVC-1:0]        empty,
    output logic [NVC*(AW+1)-1:0] count,
    output logic                  ovf_err,
    output logic                  udf_err
);

    localparam logic [AW:0] DepthCnt = (AW+1)'(2 ** AW);
    localparam logic [AW:0] AfullCnt = (AW+1)'(AFULL);

    logic [AW:0]        wptr_q [NVC];
    logic [AW:0]        wptr_d [NVC];
    logic [AW:0]        rptr_q [NVC];
    logic [AW:0]        rptr_d [NVC];
    logic [NVC-1:0]     wrHit, rdHit, wrAcc, rdAcc;
    logic [AW+VcW-1:0]  waddr, raddr;
    logic               ovf_q, ovf_d, udf_q, udf_d, vld_q;

    // Per-VC status comes straight from the registered pointers.
    // A hit that names a VC index >= NVC matches no VC, so that request is
    // ignored silently.
    for (genvar v = 0; v < NVC; v++) begin : g_vc
        logic [AW:0] cnt;
        assign cnt      = wptr_q[v] - rptr_q[v];
        assign count[v*(AW+1) +: AW+1] = cnt;
        assign empty[v] = (cnt == '0);
        assign full[v]  = (cnt == DepthCnt);
        assign afull[v] = (cnt >= AfullCnt);
        assign wrHit[v] = write && (wvc == VcW'(v));
        assign rdHit[v] = read  && (rvc == VcW'(v));
    end

    // Full blocks a write even when the same VC is read in the same cycle.
    // An accepted write targets a non-full VC and an accepted read targets a
    // non-empty VC, so the two can never address the same RAM word.
    assign wrAcc = wrHit & ~full;
    assign rdAcc = rdHit & ~empty;

    // This block computes the next pointers and the RAM addresses. At most one
    // VC is hit on each port, so the address loop simply picks that VC.
    always_comb begin
        waddr = '0;
        raddr = '0;
        for (int v = 0; v < NVC; v++) begin
            wptr_d[v] = wptr_q[v] + (AW+1)'(wrAcc[v]);
            rptr_d[v] = rptr_q[v] + (AW+1)'(rdAcc[v]);
            if (wrHit[v]) begin
                waddr = {VcW'(v), wptr_q[v][AW-1:0]};
            end
            if (rdHit[v]) begin
                raddr = {VcW'(v), rptr_q[v][AW-1:0]};
            end
        end
        ovf_d = ovf_q | (|(wrHit & full));
        udf_d = udf_q | (|(rdHit & empty));
    end

    // The pointers, the sticky error flags and the read-valid flag all clear
    // at once on reset, and reset throws away all queued contents.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int v = 0; v < NVC; v++) begin
                wptr_q[v] <= '0;
                rptr_q[v] <= '0;
            end
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
            vld_q <= 1'b0;
        end else begin
            for (int v = 0; v < NVC; v++) begin
                wptr_q[v] <= wptr_d[v];
                rptr_q[v] <= rptr_d[v];
            end
            ovf_q <= ovf_d;
            udf_q <= udf_d;
            vld_q <= |rdAcc;
        end
    end

    sdpram #(
        .AW (AW + VcW),
        .DW (DW)
    ) u_ram (
        .wclk_i  (clk),
        .we_i    (|wrAcc),
        .waddr_i (waddr),
        .wdata_i (din),
        .rclk_i  (clk),
        .rrst_ni (rstn),
        .re_i    (|rdAcc),
        .raddr_i (raddr),
        .rdata_o (dout)
    );

    assign dout_vld = vld_q;
    assign ovf_err  = ovf_q;
    assign udf_err  = udf_q;

endmodule

// File: tb/tb_vc_sync_fifo.sv
// ---------------------------------------------------------------------------
// tb_vc_sync_fifo
// Bench for vc_sync_fifo in its default geometry (NVC=4, AW=4, DW=16).
// The reference model keeps one queue per VC. After every clock edge the
// model's outputs are compared with the DUT. Directed sequences also carry
// hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_vc_sync_fifo;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        write = 1'b0;
    logic        read = 1'b0;
    logic [1:0]  wvc = '0;
    logic [1:0]  rvc = '0;
    logic [15:0] din = '0;
    logic [15:0] dout;
    logic        dout_vld;
    logic [3:0]  full, afull, empty;
    logic [19:0] count;
    logic        ovf_err, udf_err;

    int checks = 0;
    int errors = 0;

    // Reference model state: plain per-VC queues plus the expected registered outputs.
    logic [15:0] mq [4][$];
    logic [15:0] mDout = '0;
    logic        mVld = 1'b0;
    logic        mOvf = 1'b0;
    logic        mUdf = 1'b0;
    logic        wAcc, rAcc;

    vc_sync_fifo dut (
        .clk      (clk),
        .rstn     (rstn),
        .write    (write),
        .wvc      (wvc),
        .din      (din),
        .read     (read),
        .rvc      (rvc),
        .dout     (dout),
        .dout_vld (dout_vld),
        .full     (full),
        .afull    (afull),
        .empty    (empty),
        .count    (count),
        .ovf_err  (ovf_err),
        .udf_err  (udf_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Inputs are driven on the falling edge, so each call covers exactly one rising edge.
    task automatic applyStimulus(input logic w, input logic [1:0] wv, input logic [15:0] d,
                                 input logic r, input logic [1:0] rv);
        @(negedge clk);
        write = w;
        wvc   = wv;
        din   = d;
        read  = r;
        rvc   = rv;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 2'd0, 16'h0, 1'b0, 2'd0);
    endtask

    // Waits until the outputs have settled after the next rising edge.
    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic compareAll();
        checkOutput("dout_vld", int'(dout_vld), int'(mVld));
        checkOutput("dout", int'(dout), int'(mDout));
        checkOutput("ovf_err", int'(ovf_err), int'(mOvf));
        checkOutput("udf_err", int'(udf_err), int'(mUdf));
        for (int v = 0; v < 4; v++) begin
            checkOutput($sformatf("count[%0d]", v), int'(count[v*5 +: 5]), mq[v].size());
            checkOutput($sformatf("empty[%0d]", v), int'(empty[v]), int'(mq[v].size() == 0));
            checkOutput($sformatf("full[%0d]", v), int'(full[v]), int'(mq[v].size() == 16));
            checkOutput($sformatf("afull[%0d]", v), int'(afull[v]), int'(mq[v].size() >= 12));
        end
    endtask

    // Model update on each edge: acceptance is decided from the occupancy before the edge.
    always @(posedge clk) begin
        if (rstn) begin
            wAcc = write && (mq[wvc].size() < 16);
            rAcc = read && (mq[rvc].size() > 0);
            if (write && !wAcc) mOvf = 1'b1;
            if (read && !rAcc) mUdf = 1'b1;
            mVld = rAcc;
            if (rAcc) mDout = mq[rvc].pop_front();
            if (wAcc) mq[wvc].push_back(din);
        end
        #1;
        compareAll();
    end

    always @(negedge rstn) begin
        for (int v = 0; v < 4; v++) mq[v].delete();
        mDout = '0;
        mVld  = 1'b0;
        mOvf  = 1'b0;
        mUdf  = 1'b0;
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("rst empty", int'(empty), 'hF);
        checkOutput("rst full", int'(full), 0);
        checkOutput("rst count", int'(count), 0);
        checkOutput("rst dout_vld", int'(dout_vld), 0);
        checkOutput("rst errs", int'({ovf_err, udf_err}), 0);
        rstn = 1'b1;

        // Fill VC2, then drain it in FIFO order
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 2'd2, 16'h0100 + 16'(i), 1'b0, 2'd0);
        idle();
        settle();
        checkOutput("vc2 full", int'(full), 'h4);
        checkOutput("vc2 afull", int'(afull), 'h4);
        checkOutput("vc2 count", int'(count[14:10]), 16);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 2'd0, 16'h0, 1'b1, 2'd2);
            settle();
            checkOutput("vc2 rd data", int'(dout), 'h0100 + i);
            checkOutput("vc2 rd vld", int'(dout_vld), 1);
        end
        idle();
        settle();
        checkOutput("vc2 drained empty", int'(empty), 'hF);
        checkOutput("vld after idle", int'(dout_vld), 0);

        // Interleave writes to VC0 and VC3, then read VC3 first
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 2'd0, 16'hA000 + 16'(i), 1'b0, 2'd0);
            applyStimulus(1'b1, 2'd3, 16'hB000 + 16'(i), 1'b0, 2'd0);
        end
        applyStimulus(1'b0, 2'd0, 16'h0, 1'b1, 2'd3);
        settle();
        checkOutput("vc3 first", int'(dout), 'hB000);
        for (int i = 1; i < 4; i++) applyStimulus(1'b0, 2'd0, 16'h0, 1'b1, 2'd3);
        applyStimulus(1'b0, 2'd0, 16'h0, 1'b1, 2'd0);
        settle();
        checkOutput("vc0 first", int'(dout), 'hA000);
        for (int i = 1; i < 4; i++) applyStimulus(1'b0, 2'd0, 16'h0, 1'b1, 2'd0);
        idle();

        // Advance VC1 pointers by 16, hold 5 entries, then read+write for 20 cycles (pointers wrap)
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 2'd1, 16'h3000 + 16'(i), 1'b0, 2'd0);
        for (int i = 0; i < 16; i++) applyStimulus(1'b0, 2'd0, 16'h0, 1'b1, 2'd1);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 2'd1, 16'hC000 + 16'(i), 1'b0, 2'd0);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 2'd1, 16'hC005 + 16'(i), 1'b1, 2'd1);
            settle();
            checkOutput("vc1 steady count", int'(count[9:5]), 5);
            checkOutput("vc1 steady data", int'(dout), 'hC000 + i);
        end
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 2'd0, 16'h0, 1'b1, 2'd1);
        idle();

        // VC0 full: a same-cycle write and read drops the write, and the read still completes
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 2'd0, 16'hD000 + 16'(i), 1'b0, 2'd0);
        applyStimulus(1'b1, 2'd0, 16'hDEAD, 1'b1, 2'd0);
        settle();
        checkOutput("full rw ovf", int'(ovf_err), 1);
        checkOutput("full rw data", int'(dout), 'hD000);
        idle();
        settle();
        checkOutput("full rw count", int'(count[4:0]), 15);
        checkOutput("full rw full0", int'(full[0]), 0);
        for (int i = 0; i < 15; i++) applyStimulus(1'b0, 2'd0, 16'h0, 1'b1, 2'd0);
        idle();

        // Read from the empty VC1 sets udf_err, which stays set
        applyStimulus(1'b0, 2'd0, 16'h0, 1'b1, 2'd1);
        settle();
        checkOutput("udf vld", int'(dout_vld), 0);
        checkOutput("udf set", int'(udf_err), 1);
        idle();
        repeat (2) @(negedge clk);
        checkOutput("udf sticky", int'(udf_err), 1);

        // Reset asserted mid-burst
        applyStimulus(1'b1, 2'd2, 16'h5550, 1'b0, 2'd0);
        applyStimulus(1'b1, 2'd2, 16'h5551, 1'b1, 2'd0);
        applyStimulus(1'b1, 2'd2, 16'h5552, 1'b1, 2'd2);
        @(posedge clk);
        #3;
        rstn = 1'b0;
        #1;
        checkOutput("mid rst empty", int'(empty), 'hF);
        checkOutput("mid rst full", int'(full), 0);
        checkOutput("mid rst afull", int'(afull), 0);
        checkOutput("mid rst count", int'(count), 0);
        checkOutput("mid rst dout", int'(dout), 0);
        checkOutput("mid rst vld", int'(dout_vld), 0);
        checkOutput("mid rst errs", int'({ovf_err, udf_err}), 0);
        idle();
        @(negedge clk);
        rstn = 1'b1;

        // Normal operation resumes after reset
        applyStimulus(1'b1, 2'd3, 16'h1234, 1'b0, 2'd0);
        applyStimulus(1'b0, 2'd0, 16'h0, 1'b1, 2'd3);
        settle();
        checkOutput("post rst data", int'(dout), 'h1234);
        checkOutput("post rst vld", int'(dout_vld), 1);
        idle();
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
